psum_requant_serializer: RTL and testbench

- Downstream stage of the dense compute core.
- Captures one 32-row partial-sum vector (32 x 32-bit signed, flattened) per output pixel group.
- Requantizes each row to signed int8: multiply, round-shift, optional ReLU, zero-point add, saturate.
- Streams the 32 results one per cycle over a valid/ready interface toward the output write-back path.

---
 rtl/psum_requant_serializer_pkg.sv | 38 +++
 rtl/psum_requant_serializer_requant_pipe.sv | 118 +++++++++++
 rtl/psum_requant_serializer.sv | 125 ++++++++++++
 tb/tb_psum_requant_serializer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_serializer_pkg.sv
// Shared widths, output limits, FSM encoding and the int8 saturation helper
// for the partial-sum requantize/serialize stage.
package psum_requant_serializer_pkg;

    localparam int PSUM_BW  = 32;
    localparam int NUM_ROWS = 32;
    localparam int OUT_BW   = 8;
    localparam int SCALE_BW = 16;
    localparam int SHIFT_BW = 6;

    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int PROD_W = PSUM_BW + SCALE_BW + 1;
    localparam int SHR_W  = PROD_W + 1;
    // The rounding bias can reach 2^(2^SHIFT_BW - 2), so the pre-shift sum needs extra headroom.
    localparam int RND_W  = ((PROD_W > (1 << SHIFT_BW)) ? PROD_W : (1 << SHIFT_BW)) + 1;
    localparam int SAT_W  = SHR_W + 1;

    localparam logic signed [OUT_BW-1:0] OUT_MAX = {1'b0, {(OUT_BW-1){1'b1}}};
    localparam logic signed [OUT_BW-1:0] OUT_MIN = {1'b1, {(OUT_BW-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic logic signed [OUT_BW-1:0] saturate(input logic signed [SAT_W-1:0] v);
        logic signed [OUT_BW-1:0] r;
        if (v > SAT_W'(OUT_MAX)) begin
            r = OUT_MAX;
        end else if (v < SAT_W'(OUT_MIN)) begin
            r = OUT_MIN;
        end else begin
            r = v[OUT_BW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_requant_serializer_requant_pipe.sv
// Three-stage requant datapath: multiply, round-half-up shift, ReLU/zero-point/saturate.
// Per-row config travels with the data so a newly captured vector cannot disturb rows in flight.
module requant_pipe
    import psum_requant_serializer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid_i,
    input  logic signed [PSUM_BW-1:0]  psum_i,
    input  logic        [SCALE_BW-1:0] scale_i,
    input  logic        [SHIFT_BW-1:0] shift_i,
    input  logic signed [OUT_BW-1:0]   zero_point_i,
    input  logic                       relu_en_i,
    input  logic        [ROW_W-1:0]    row_i,
    input  logic                       last_i,
    input  logic                       out_ready_i,
    output logic                       advance_o,
    output logic                       out_valid_o,
    output logic signed [OUT_BW-1:0]   out_data_o,
    output logic        [ROW_W-1:0]    out_row_o,
    output logic                       out_last_o
);

    logic                       s1_valid_q;
    logic signed [PROD_W-1:0]   s1_prod_q;
    logic        [SHIFT_BW-1:0] s1_shift_q;
    logic signed [OUT_BW-1:0]   s1_zp_q;
    logic                       s1_relu_q;
    logic        [ROW_W-1:0]    s1_row_q;
    logic                       s1_last_q;

    logic                       s2_valid_q;
    logic signed [SHR_W-1:0]    s2_shr_q;
    logic signed [OUT_BW-1:0]   s2_zp_q;
    logic                       s2_relu_q;
    logic        [ROW_W-1:0]    s2_row_q;
    logic                       s2_last_q;

    logic                       s3_valid_q;
    logic signed [OUT_BW-1:0]   s3_data_q;
    logic        [ROW_W-1:0]    s3_row_q;
    logic                       s3_last_q;

    logic signed [PROD_W-1:0]   s1_prod_d;
    logic signed [RND_W-1:0]    rnd_bias;
    logic signed [RND_W-1:0]    rnd_sum;
    logic signed [SHR_W-1:0]    s2_shr_d;
    logic signed [SHR_W-1:0]    relu_v;
    logic signed [SAT_W-1:0]    biased;
    logic signed [OUT_BW-1:0]   s3_data_d;

    assign advance_o = !s3_valid_q || out_ready_i;

    always_comb begin
        s1_prod_d = PROD_W'(psum_i) * PROD_W'($signed({1'b0, scale_i}));

        rnd_bias = '0;
        if (s1_shift_q != '0) begin
            rnd_bias = RND_W'(1) << (s1_shift_q - SHIFT_BW'(1));
        end
        rnd_sum  = RND_W'(s1_prod_q) + rnd_bias;
        s2_shr_d = SHR_W'(rnd_sum >>> s1_shift_q);

        relu_v = s2_shr_q;
        if (s2_relu_q && s2_shr_q[SHR_W-1]) begin
            relu_v = '0;
        end
        biased    = SAT_W'(relu_v) + SAT_W'(s2_zp_q);
        s3_data_d = saturate(biased);
    end

    // Every stage shares one advance enable, so a stalled consumer freezes the whole pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
            s1_relu_q  <= 1'b0;
            s1_row_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_shr_q   <= '0;
            s2_zp_q    <= '0;
            s2_relu_q  <= 1'b0;
            s2_row_q   <= '0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_row_q   <= '0;
            s3_last_q  <= 1'b0;
        end else if (advance_o) begin
            s1_valid_q <= issue_valid_i;
            s1_prod_q  <= s1_prod_d;
            s1_shift_q <= shift_i;
            s1_zp_q    <= zero_point_i;
            s1_relu_q  <= relu_en_i;
            s1_row_q   <= row_i;
            s1_last_q  <= last_i;
            s2_valid_q <= s1_valid_q;
            s2_shr_q   <= s2_shr_d;
            s2_zp_q    <= s1_zp_q;
            s2_relu_q  <= s1_relu_q;
            s2_row_q   <= s1_row_q;
            s2_last_q  <= s1_last_q;
            s3_valid_q <= s2_valid_q;
            s3_data_q  <= s3_data_d;
            s3_row_q   <= s2_row_q;
            s3_last_q  <= s2_last_q;
        end
    end

    assign out_valid_o = s3_valid_q;
    assign out_data_o  = s3_data_q;
    assign out_row_o   = s3_row_q;
    assign out_last_o  = s3_last_q;

endmodule

// File: rtl/psum_requant_serializer.sv
// Captures a partial-sum vector plus its requant config, then issues one row per
// cycle into the requant pipe and streams int8 results over valid/ready.
module psum_requant_serializer
    import psum_requant_serializer_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PSUM_BW*NUM_ROWS-1:0]  psum_rows,
    input  logic [SCALE_BW-1:0]          cfg_scale,
    input  logic [SHIFT_BW-1:0]          cfg_shift,
    input  logic signed [OUT_BW-1:0]     cfg_zero_point,
    input  logic                         cfg_relu_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_BW-1:0]     out_data,
    output logic [ROW_W-1:0]             out_row,
    output logic                         out_last,
    output logic                         tile_done
);

    state_e                      state_q, state_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [PSUM_BW*NUM_ROWS-1:0] psum_q;
    logic [SCALE_BW-1:0]         scale_q;
    logic [SHIFT_BW-1:0]         shift_q;
    logic signed [OUT_BW-1:0]    zp_q;
    logic                        relu_q;
    logic                        tile_done_q;

    logic                        capture;
    logic                        issue_valid;
    logic                        issue_last;
    logic                        advance;

    assign issue_last = (row_q == ROW_W'(NUM_ROWS - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        capture     = 1'b0;
        issue_valid = 1'b0;
        in_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    row_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (advance) begin
                    row_d = row_q + ROW_W'(1);
                    if (issue_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // The config is sampled with the vector, so later cfg_* changes never touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_q  <= '0;
            scale_q <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
        end else if (capture) begin
            psum_q  <= psum_rows;
            scale_q <= cfg_scale;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zero_point;
            relu_q  <= cfg_relu_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= out_valid && out_ready && out_last;
        end
    end

    assign tile_done = tile_done_q;

    requant_pipe u_pipe (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid),
        .psum_i        ($signed(psum_q[int'(row_q)*PSUM_BW +: PSUM_BW])),
        .scale_i       (scale_q),
        .shift_i       (shift_q),
        .zero_point_i  (zp_q),
        .relu_en_i     (relu_q),
        .row_i         (row_q),
        .last_i        (issue_last),
        .out_ready_i   (out_ready),
        .advance_o     (advance),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .out_row_o     (out_row),
        .out_last_o    (out_last)
    );

endmodule

// File: tb/tb_psum_requant_serializer.sv
// Scoreboard bench for psum_requant_serializer: expected rows are queued when a
// vector is offered and compared as the DUT hands each row over.
module tb_psum_requant_serializer;

    localparam int NR = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [NR*32-1:0]    psum_rows;
    logic [15:0]         cfg_scale;
    logic [5:0]          cfg_shift;
    logic signed [7:0]   cfg_zero_point;
    logic                cfg_relu_en;
    logic                out_valid;
    logic                out_ready;
    logic signed [7:0]   out_data;
    logic [4:0]          out_row;
    logic                out_last;
    logic                tile_done;

    typedef struct {
        logic signed [7:0] data;
        logic [4:0]        row;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    psum_requant_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .psum_rows      (psum_rows),
        .cfg_scale      (cfg_scale),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .cfg_relu_en    (cfg_relu_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_last       (out_last),
        .tile_done      (tile_done)
    );

    always #5 clk = ~clk;

    // Reference: exact product, floor((p + 2^(s-1)) / 2^s), ReLU, offset, clamp.
    function automatic logic signed [7:0] model(input int psum, input int scale, input int shift,
                                                input int zp, input bit relu);
        longint p, d, n, q;
        p = longint'(psum) * longint'(scale);
        if (shift == 0) begin
            q = p;
        end else begin
            d = longint'(1) << shift;
            n = p + d / 2;
            q = n / d;
            if ((n % d) != 0 && n < 0) q = q - 1;
        end
        if (relu && q < 0) q = 0;
        q = q + zp;
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
        return 8'(q);
    endfunction

    task automatic send_vector(input int vals[NR], input int scale, input int shift,
                               input int zp, input bit relu);
        int   budget = 0;
        exp_t e;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        for (int r = 0; r < NR; r++) begin
            psum_rows[r*32 +: 32] = vals[r];
            e.data = model(vals[r], scale, shift, zp, relu);
            e.row  = 5'(r);
            e.last = (r == NR - 1);
            sb.push_back(e);
        end
        cfg_scale      = 16'(scale);
        cfg_shift      = 6'(shift);
        cfg_zero_point = 8'(zp);
        cfg_relu_en    = relu;
        in_valid       = 1'b1;
        @(negedge clk);
        in_valid       = 1'b0;
        cfg_scale      = 16'($urandom);
        cfg_shift      = 6'($urandom);
        cfg_zero_point = 8'($urandom);
        cfg_relu_en    = 1'($urandom);
        psum_rows      = {NR{$urandom}};
    endtask

    // Drains n rows; optionally holds out_ready low for stall_len cycles when stall_row shows.
    task automatic stream(input int n, input int stall_row, input int stall_len,
                          input bit check_gaps, input int exp_tiles);
        int   got = 0, cyc = 0, stalled = 0, gaps = 0, tiles = 0;
        bit   seen = 0, v, rdy;
        exp_t e;
        while (got < n && cyc < n * 4 + 200) begin
            v = out_valid;
            if (tile_done) tiles++;
            rdy = 1'b1;
            if (v && int'(out_row) == stall_row && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            out_ready = rdy;
            if (v) seen = 1;
            else if (seen) gaps++;
            if (v && sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_row: row=%0d data=%0d, required no output", out_row, out_data);
            end else if (v && rdy) begin
                e = sb.pop_front();
                got++;
                compared++;
                if (out_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL out_data row %0d: got %0d, want %0d", e.row, out_data, e.data);
                end
                compared++;
                if (out_row !== e.row) begin
                    mismatched++;
                    $display("[TB] FAIL out_row: got %0d, want %0d", out_row, e.row);
                end
                compared++;
                if (out_last !== e.last) begin
                    mismatched++;
                    $display("[TB] FAIL out_last row %0d: got %b, want %b", e.row, out_last, e.last);
                end
            end else if (v && !rdy) begin
                e = sb[0];
                compared++;
                if (out_data !== e.data || out_row !== e.row || in_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: data=%0d row=%0d in_ready=%b, want data=%0d row=%0d in_ready=0",
                             out_data, out_row, in_ready, e.data, e.row);
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        compared++;
        if (got != n) begin
            mismatched++;
            $display("[TB] FAIL stream_timeout: got %0d rows, want %0d", got, n);
        end
        repeat (3) begin
            if (tile_done) tiles++;
            @(negedge clk);
        end
        compared++;
        if (tiles != exp_tiles) begin
            mismatched++;
            $display("[TB] FAIL tile_done_count: got %0d, want %0d", tiles, exp_tiles);
        end
        if (check_gaps) begin
            compared++;
            if (gaps != 0) begin
                mismatched++;
                $display("[TB] FAIL valid_gaps: got %0d, want 0", gaps);
            end
        end
        if (stall_len > 0) begin
            compared++;
            if (stalled != stall_len) begin
                mismatched++;
                $display("[TB] FAIL stall_cycles: got %0d, want %0d", stalled, stall_len);
            end
        end
    endtask

    task automatic fill_random(output int vals[NR]);
        for (int r = 0; r < NR; r++) vals[r] = int'($urandom_range(0, 2000)) - 1000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'sd0 ||
            out_row !== 5'd0 || out_last !== 1'b0 || tile_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: in_ready=%b out_valid=%b data=%0d row=%0d last=%b done=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_row, out_last, tile_done);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_identity();
        int vals[NR];
        for (int r = 0; r < NR; r++) vals[r] = r - 16;
        send_vector(vals, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL latency_early: out_valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL latency_first: out_valid=%b, want 1", out_valid);
        end
        stream(NR, -1, 0, 1'b1, 1);
    endtask

    task automatic test_rounding();
        int vals[NR];
        fill_random(vals);
        vals[0] = 5;
        vals[1] = -5;
        send_vector(vals, 3, 2, 0, 0);
        stream(NR, -1, 0, 1'b0, 1);
        fill_random(vals);
        vals[0] = -14;
        vals[1] = 6;
        send_vector(vals, 1, 2, 0, 0);
        stream(NR, -1, 0, 1'b0, 1);
    endtask

    task automatic test_saturation();
        int vals[NR];
        fill_random(vals);
        vals[0] = 1000000;
        vals[1] = -1000000;
        send_vector(vals, 1, 0, 0, 0);
        stream(NR, -1, 0, 1'b0, 1);
        fill_random(vals);
        vals[2] = 120;
        send_vector(vals, 1, 0, 10, 0);
        stream(NR, -1, 0, 1'b0, 1);
    endtask

    task automatic test_relu();
        int vals[NR];
        fill_random(vals);
        vals[0] = -50;
        vals[1] = 50;
        send_vector(vals, 1, 0, -128, 1);
        stream(NR, -1, 0, 1'b0, 1);
        send_vector(vals, 1, 0, -128, 0);
        stream(NR, -1, 0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        int a[NR];
        int b[NR];
        fill_random(a);
        fill_random(b);
        fork
            begin
                send_vector(a, 2, 1, 5, 0);
                send_vector(b, 7, 3, -3, 1);
            end
            stream(2 * NR, -1, 0, 1'b0, 2);
        join
    endtask

    task automatic test_backpressure();
        int vals[NR];
        fill_random(vals);
        send_vector(vals, 1, 0, 0, 0);
        stream(NR, 4, 5, 1'b1, 1);
    endtask

    task automatic test_reset_midstream();
        int vals[NR];
        int budget = 0;
        fill_random(vals);
        send_vector(vals, 1, 0, 0, 0);
        while (!(out_valid && out_row == 5'd10) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        compared++;
        if (!(out_valid && out_row == 5'd10)) begin
            mismatched++;
            $display("[TB] FAIL reach_row10: out_valid=%b row=%0d, want 1 10", out_valid, out_row);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: out_valid=%b, want 0", out_valid);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        for (int r = 0; r < NR; r++) vals[r] = 7;
        send_vector(vals, 1, 0, 0, 0);
        stream(NR, -1, 0, 1'b1, 1);
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        psum_rows      = '0;
        cfg_scale      = '0;
        cfg_shift      = '0;
        cfg_zero_point = '0;
        cfg_relu_en    = 1'b0;
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_relu();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
